mod_reduce_r: RTL and testbench
===============================

Name: mod_reduce_r

Overview:
- Sequential modular reducer directly downstream of the exponentiation stage in the Diffie-Hellman datapath.
- Takes the 64-bit exponentiation result and the 32-bit public prime p, and produces R = value mod p for the key-exchange output.
- Radix-2 restoring shift-subtract: one dividend bit per clock, no multiplier or divider inferred.
- Uses the same level-held start/done handshake as the exponentiation stage, so the two chain directly.

Parameters:
- DW, 64, dividend width (matches the upstream result width).
- MW, 32, modulus width (prime p).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  level request; must stay high for the whole operation; dropping it aborts or clears.
- dividend  input  DW  value to reduce; captured in the cycle start is first sampled in IDLE.
- modulus  input  MW  prime p; captured with dividend.
- remainder  output  MW  dividend mod modulus; valid while done=1.
- done  output  1  result valid; held while start stays high.
- busy  output  1  high in CALC.
- err  output  1  captured modulus was 0; valid while done=1.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; remainder=0, done=0, busy=0, err=0.
  - Internal partial remainder, dividend shadow and bit index are cleared.
- States: IDLE, CALC, DONE. All registered, one clock domain.
- IDLE:
  - Wait for start=1.
  - On the first edge with start=1: capture dividend into shadow D and modulus into M, set partial remainder P=0 and index i=DW-1.
  - If M≠0: go to CALC with busy=1.
  - If modulus=0: go directly to DONE with err=1, remainder=0.
- CALC, one step per edge:
  - T = {P[MW-1:0], D[i]} (MW+1 bits).
  - If T >= {1'b0, M}: P = T - M; else P = T[MW-1:0].
  - Decrement i.
  - After the step with i=0: go to DONE, remainder=P, done=1, busy=0.
- Latency: done rises exactly DW+1 rising edges after the edge that first samples start=1 in IDLE (65 for the defaults). Error path: 1 edge.
- DONE:
  - Hold remainder, done and err while start=1.
  - start=0: return to IDLE; done, err and busy clear on that edge. remainder keeps its last value.
- Abort: start=0 during CALC returns to IDLE on the next edge. done is never asserted and the partial result is discarded.
- Operand changes after capture are ignored until the next IDLE capture.
- Width rules:
  - T is MW+1 bits, so no overflow; P < M always holds.
  - The result is exact for every dividend in [0, 2^DW-1] and modulus in [1, 2^MW-1].
- Boundaries:
  - dividend < modulus: remainder = dividend[MW-1:0].
  - modulus=1: remainder=0.
  - dividend = modulus: remainder=0.
  - dividend=0: remainder=0 after the full latency; there is no early exit, so latency is constant.
- Reset mid-operation: immediate return to the reset values, regardless of state.

Decomposition:
- Shared package dh_pkg:
  - DW/MW localparams, shared with the exponentiation stage.
  - State encoding IDLE=2'd0, CALC=2'd1, DONE=2'd2.
- One natural sub-module, mod_sub_step: combinational, takes P, the incoming bit and M, and returns the next P.
  - Keeps the FSM and datapath separate.
  - Allows later unrolling to radix-4 by instancing it twice per cycle.

Test Plan:
- dividend=100, modulus=23, start held high → done at edge 65, remainder=8, err=0, busy high for edges 1-64.
- dividend=0xFFFF_FFFF_FFFF_FFFF, modulus=0xFFFF_FFFB → remainder=24 (0x18), done at edge 65.
- dividend=5, modulus=7 → remainder=5. Also dividend=0x1_0000_0000, modulus=1 → remainder=0. Both with done at edge 65.
- modulus=0, dividend=1234 → err=1, done=1, remainder=0 one edge after start. Drop start → done=0 and err=0 on the next edge.
- start dropped at edge 30 of CALC → busy=0 next edge, done never rises. Re-assert with dividend=1000, modulus=97 → remainder=30 at edge 65.
- rst pulsed low at edge 40 of CALC → all outputs 0 asynchronously. After release, a fresh start with dividend=100, modulus=23 → remainder=8.

Source files
------------

// File: rtl/dh_pkg.sv
// Shared widths and FSM encoding for the Diffie-Hellman datapath stages.
package dh_pkg;

  localparam int DW = 64;  // exponentiation result / dividend width
  localparam int MW = 32;  // public prime width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } red_state_t;

endpackage

// File: rtl/mod_sub_step.sv
// One restoring shift-subtract step: shifts one dividend bit into the
// partial remainder and subtracts the modulus when it fits.
module mod_sub_step #(
  parameter int MW = 32
) (
  input  logic [MW-1:0] p_in,
  input  logic          bit_in,
  input  logic [MW-1:0] m_in,
  output logic [MW-1:0] p_out
);

  logic [MW:0] t;
  logic [MW:0] diff;

  // T is one bit wider than M, so the compare and subtract never overflow.
  always_comb begin
    t    = {p_in, bit_in};
    diff = t - {1'b0, m_in};
    if (t >= {1'b0, m_in}) begin
      p_out = diff[MW-1:0];
    end else begin
      p_out = t[MW-1:0];
    end
  end

endmodule

// File: rtl/mod_reduce_r.sv
// Sequential modular reducer: remainder = dividend mod modulus, one dividend
// bit per clock, level-held start/done handshake shared with the upstream stage.
module mod_reduce_r
  import dh_pkg::*;
#(
  parameter int DW_P = DW,
  parameter int MW_P = MW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW_P-1:0] dividend,
  input  logic [MW_P-1:0] modulus,
  output logic [MW_P-1:0] remainder,
  output logic            done,
  output logic            busy,
  output logic            err
);

  localparam int IW = (DW_P > 1) ? $clog2(DW_P) : 1;

  red_state_t      state_reg, state_next;
  logic [MW_P-1:0] p_reg, p_next;
  logic [DW_P-1:0] d_reg, d_next;
  logic [MW_P-1:0] m_reg, m_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [MW_P-1:0] remainder_reg, remainder_next;
  logic            done_reg, done_next;
  logic            busy_reg, busy_next;
  logic            err_reg, err_next;

  logic [MW_P-1:0] step_p;

  mod_sub_step #(
    .MW(MW_P)
  ) u_step (
    .p_in  (p_reg),
    .bit_in(d_reg[idx_reg]),
    .m_in  (m_reg),
    .p_out (step_p)
  );

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      p_reg         <= '0;
      d_reg         <= '0;
      m_reg         <= '0;
      idx_reg       <= '0;
      remainder_reg <= '0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      p_reg         <= p_next;
      d_reg         <= d_next;
      m_reg         <= m_next;
      idx_reg       <= idx_next;
      remainder_reg <= remainder_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
      err_reg       <= err_next;
    end
  end

  // Next-state and datapath update; every register holds unless changed.
  always_comb begin
    state_next     = state_reg;
    p_next         = p_reg;
    d_next         = d_reg;
    m_next         = m_reg;
    idx_next       = idx_reg;
    remainder_next = remainder_reg;
    done_next      = done_reg;
    busy_next      = busy_reg;
    err_next       = err_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          d_next   = dividend;
          m_next   = modulus;
          p_next   = '0;
          idx_next = IW'(DW_P - 1);
          if (modulus != '0) begin
            state_next = CALC;
            busy_next  = 1'b1;
          end else begin
            // Zero modulus has no defined remainder: flag it straight away.
            state_next     = DONE;
            done_next      = 1'b1;
            err_next       = 1'b1;
            remainder_next = '0;
          end
        end
      end

      CALC: begin
        if (!start) begin
          // Abort: partial result is simply abandoned.
          state_next = IDLE;
          busy_next  = 1'b0;
        end else begin
          p_next   = step_p;
          idx_next = idx_reg - 1'b1;
          if (idx_reg == '0) begin
            state_next     = DONE;
            remainder_next = step_p;
            done_next      = 1'b1;
            busy_next      = 1'b0;
          end
        end
      end

      DONE: begin
        if (!start) begin
          state_next = IDLE;
          done_next  = 1'b0;
          err_next   = 1'b0;
          busy_next  = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
        done_next  = 1'b0;
        err_next   = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign remainder = remainder_reg;
  assign done      = done_reg;
  assign busy      = busy_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_mod_reduce_r.sv
// Self-checking bench for mod_reduce_r: expected results are queued when an
// operation is launched and compared when done rises.
module tb_mod_reduce_r;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] dividend;
  logic [31:0] modulus;
  logic [31:0] remainder;
  logic        done;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rem;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  mod_reduce_r dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .modulus  (modulus),
    .remainder(remainder),
    .done     (done),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Launch one reduction, wait for done, compare against the scoreboard,
  // then check hold behaviour and release.
  task automatic do_op(input logic [63:0] dv, input logic [31:0] md);
    exp_t e;
    exp_t got;
    int   edges;
    bit   busy_bad;
    logic [31:0] rem_seen;
    e.err = (md == 32'd0);
    e.rem = e.err ? 32'd0 : 32'(dv % {32'd0, md});
    e.lat = e.err ? 1 : 65;
    sb_q.push_back(e);

    @(negedge clk);
    dividend = dv;
    modulus  = md;
    start    = 1'b1;
    edges    = 0;
    busy_bad = 1'b0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        // Operands must be ignored once captured.
        dividend = ~dv;
        modulus  = md + 32'd1;
      end
      if (!done && !busy) busy_bad = 1'b1;
      if (done && busy) busy_bad = 1'b1;
    end while (!done && edges < 200);

    if (sb_q.size() == 0) begin
      check_val("sb_empty", 64'd1, 64'd0);
    end else begin
      got = sb_q.pop_front();
      check_val("latency", 64'(edges), 64'(got.lat));
      check_val("done", {63'd0, done}, 64'd1);
      check_val("remainder", {32'd0, remainder}, {32'd0, got.rem});
      check_val("err", {63'd0, err}, {63'd0, got.err});
      check_val("busy_profile", {63'd0, busy_bad}, 64'd0);
      $display("op dividend=0x%016h modulus=0x%08h -> rem=0x%08h err=%0b lat=%0d",
               dv, md, remainder, err, edges);
    end

    // Hold while start stays high.
    rem_seen = remainder;
    repeat (3) @(posedge clk);
    #1;
    check_val("hold_done", {63'd0, done}, 64'd1);
    check_val("hold_rem", {32'd0, remainder}, {32'd0, rem_seen});

    // Release: done/err clear on the next edge, remainder kept.
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_val("rel_done", {63'd0, done}, 64'd0);
    check_val("rel_err", {63'd0, err}, 64'd0);
    check_val("rel_rem", {32'd0, remainder}, {32'd0, rem_seen});
  endtask

  // Start an operation and drop/reset part-way through CALC.
  task automatic start_and_wait(input logic [63:0] dv, input logic [31:0] md, input int n);
    @(negedge clk);
    dividend = dv;
    modulus  = md;
    start    = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    dividend = '0;
    modulus  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_rem", {32'd0, remainder}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_err", {63'd0, err}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    do_op(64'd100, 32'd23);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFB);
    do_op(64'd5, 32'd7);
    do_op(64'h1_0000_0000, 32'd1);
    do_op(64'd1234, 32'd0);
    do_op(64'd0, 32'd13);
    do_op(64'd977, 32'd977);

    // Abort after 30 CALC edges.
    start_and_wait(64'd999_999, 32'd101, 30);
    check_val("abort_busy_pre", {63'd0, busy}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_val("abort_busy", {63'd0, busy}, 64'd0);
    check_val("abort_done", {63'd0, done}, 64'd0);
    repeat (70) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    check_val("abort_no_done", {63'd0, done}, 64'd0);
    $display("op abort after 30 edges: busy=%0b done=%0b", busy, done);
    do_op(64'd1000, 32'd97);

    // Asynchronous reset in the middle of CALC.
    start_and_wait(64'd123_456_789, 32'd1009, 40);
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_rem", {32'd0, remainder}, 64'd0);
    check_val("arst_busy", {63'd0, busy}, 64'd0);
    check_val("arst_done", {63'd0, done}, 64'd0);
    check_val("arst_err", {63'd0, err}, 64'd0);
    $display("op async reset mid-CALC: rem=0x%08h busy=%0b", remainder, busy);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_op(64'd100, 32'd23);

    // A few random operands.
    for (int k = 0; k < 4; k++) begin
      logic [63:0] rdv;
      logic [31:0] rmd;
      rdv = {$urandom, $urandom};
      rmd = $urandom;
      if (rmd == 32'd0) rmd = 32'd3;
      do_op(rdv, rmd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
